param_seven_segment_scanner: RTL

//  Next-generation multiplexed hex display driver for N common-anode digits.

---
 rtl/seg7_pkg.sv | 12 +
 rtl/seg7_glyph_decoder.sv | 9 +
 rtl/param_seven_segment_scanner.sv | 111 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table and idle-pin constants shared by the seven-segment scanner.
package seg7_pkg;
   localparam int MAX_DIGITS = 16;
   typedef logic [$clog2(MAX_DIGITS)-1:0] digit_t;
   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;
   // active-low segments g..a, entry n is the glyph for nibble n
   localparam logic [15:0][6:0] GLYPHS = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };
endpackage

// File: rtl/seg7_glyph_decoder.sv
// seg7_glyph_decoder: combinational hex nibble to active-low 7-segment glyph.
module seg7_glyph_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   assign seg = GLYPHS[nibble];
endmodule

// File: rtl/param_seven_segment_scanner.sv
// param_seven_segment_scanner: multiplexed common-anode hex display driver with
// double-buffered content, PWM brightness, blink and leading-zero blanking.
module param_seven_segment_scanner
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int DIGIT_PERIOD = 1024,
   parameter int BRIGHT_W     = 4,
   parameter int BLINK_FRAMES = 256
) (
   input  logic                            system_clock,
   input  logic                            cpu_rst,
   input  logic [4*NUM_DIGITS-1:0]         value_in,
   input  logic [NUM_DIGITS-1:0]           dot_mask,
   input  logic [NUM_DIGITS-1:0]           blink_mask,
   input  logic                            load,
   input  logic                            blank_lz,
   input  logic [BRIGHT_W-1:0]             brightness,
   output logic [6:0]                      cathodes_out,
   output logic                            dot,
   output logic [NUM_DIGITS-1:0]           anode_out,
   output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
   output logic                            frame_start
);
   localparam int DW   = $clog2(NUM_DIGITS);
   localparam int SW   = $clog2(DIGIT_PERIOD);
   localparam int FW   = $clog2(BLINK_FRAMES + 1);
   localparam int STEP = DIGIT_PERIOD >> BRIGHT_W;

   logic [SW-1:0] slot_cnt, phase;
   digit_t digit_cnt;
   logic [DW-1:0] dsel;
   logic [FW-1:0] frame_cnt;
   logic blink_ph, pend_vld, act_vld, cur_vld, slot0, frame0, slot_end, last_digit, lz, lit;
   logic [4*NUM_DIGITS-1:0] pend_val, act_val, cur_val, val_sh;
   logic [NUM_DIGITS-1:0] pend_dot, act_dot, cur_dot, pend_blk, act_blk, cur_blk, anode_nx;
   logic [BRIGHT_W-1:0] bright_q, bright;
   logic [3:0] nibble;
   logic [6:0] glyph;

   assign slot0      = slot_cnt == '0;
   assign slot_end   = slot_cnt == SW'(DIGIT_PERIOD - 1);
   assign last_digit = digit_cnt == digit_t'(NUM_DIGITS - 1);
   assign frame0     = slot0 && digit_cnt == '0;
   assign dsel       = digit_cnt[DW-1:0];
   // the frame being shown switches to the pending buffer at its first slot, with a same-cycle load taking priority
   assign {cur_vld, cur_val, cur_dot, cur_blk} = !frame0 ? {act_vld, act_val, act_dot, act_blk} :
                                                 load ? {1'b1, value_in, dot_mask, blink_mask} :
                                                 {pend_vld, pend_val, pend_dot, pend_blk};
   assign bright = slot0 ? brightness : bright_q;
   assign phase  = SW'(32'(slot_cnt) / STEP);
   assign val_sh = cur_val << (4 * int'(digit_cnt));
   assign nibble = val_sh[4*NUM_DIGITS-1 -: 4];

   always_comb begin
      logic [4*NUM_DIGITS-1:0] v;
      logic [NUM_DIGITS-1:0] m;
      logic run;
      v = cur_val;
      m = cur_dot;
      run = 1'b1;
      lz = 1'b0;
      for (int i = 0; i < NUM_DIGITS - 1; i++) begin
         run = run && v[4*NUM_DIGITS-1 -: 4] == 4'h0 && !m[0];
         lz = (digit_t'(i) == digit_cnt) ? blank_lz && run : lz;
         v = v << 4;
         m = m >> 1;
      end
   end

   assign lit = cur_vld && !lz && !(blink_ph && cur_blk[dsel]) && phase <= SW'(bright);
   assign anode_nx = lit ? ~(NUM_DIGITS'(1) << (NUM_DIGITS - 1 - int'(digit_cnt))) : ANODE_OFF[NUM_DIGITS-1:0];

   seg7_glyph_decoder u_dec (.nibble(nibble), .seg(glyph));

   always_ff @(posedge system_clock or posedge cpu_rst)
      if (cpu_rst) begin
         slot_cnt <= '0;
         digit_cnt <= '0;
         frame_cnt <= '0;
         blink_ph <= 1'b0;
         {pend_vld, pend_val, pend_dot, pend_blk} <= '0;
         {act_vld, act_val, act_dot, act_blk} <= '0;
         bright_q <= '0;
         anode_out <= ANODE_OFF[NUM_DIGITS-1:0];
         cathodes_out <= SEG_OFF;
         dot <= 1'b1;
         digit_idx <= '0;
         frame_start <= 1'b0;
      end else begin
         slot_cnt <= slot_end ? '0 : slot_cnt + SW'(1);
         if (slot_end)
            digit_cnt <= last_digit ? '0 : digit_cnt + digit_t'(1);
         if (slot_end && last_digit) begin
            frame_cnt <= frame_cnt == FW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + FW'(1);
            if (frame_cnt == FW'(BLINK_FRAMES - 1))
               blink_ph <= !blink_ph;
         end
         if (load)
            {pend_vld, pend_val, pend_dot, pend_blk} <= {1'b1, value_in, dot_mask, blink_mask};
         if (frame0)
            {act_vld, act_val, act_dot, act_blk} <= {cur_vld, cur_val, cur_dot, cur_blk};
         if (slot0)
            bright_q <= brightness;
         anode_out <= anode_nx;
         cathodes_out <= glyph;
         dot <= !cur_dot[dsel];
         digit_idx <= dsel;
         frame_start <= frame0;
      end
endmodule
